relm_uart_tx_io: RTL and testbench

- Serial transmitter peripheral that sits on one PE push channel, the responder end of the push handshake.
- The relm ring pushes words {strobe, data}. The block queues one word in a holding register and shifts characters out on an asynchronous serial line (8N1-style, LSB first).
- It raises push_retry to back-pressure the ring while the holding register is occupied.
- Control words on the same channel reprogram the baud divisor, in order with characters.

---
 rtl/relm_uart_tx_io.sv | 185 ++++++++++++++++++
 tb/tb_relm_uart_tx_io.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relm_uart_tx_io.sv
// relm_uart_tx_io: serial transmitter on a relm push channel (responder end).
// One pushed word is kept in a holding register; characters are sent 8N1-style,
// LSB first, on txd_out. Control words in the same stream reprogram the baud
// divisor, taking effect in stream order between frames.
//
// Push handshake (valid/ready): push_d[WD] is the valid strobe and
// push_retry is the inverted ready. A word is taken on a rising edge where the
// strobe is high and push_retry is low. When push_retry is high, the word is
// dropped and the pusher must reissue it later. push_retry depends only on
// registered state.
module relm_uart_tx_io #(
  parameter int WD    = 32,
  parameter int WCHAR = 8,
  parameter int WDIV  = 16,
  parameter int DIV   = 868,
  parameter int NSTOP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  output logic        txd_out,
  output logic        busy_out
);

  // Payload bits worth keeping: enough for a character or a divisor value.
  localparam int HW  = (WDIV > WCHAR) ? WDIV : WCHAR;
  localparam int BIW = (WCHAR > 1) ? $clog2(WCHAR) : 1;
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(WCHAR - 1);
  localparam logic           LAST_STOP = (NSTOP == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic            hold_valid;
  logic            hold_cmd;
  logic [HW-1:0]   hold_val;
  logic [WDIV-1:0] divisor;
  logic [WDIV-1:0] cnt;
  logic [BIW-1:0]  bit_idx;
  logic            stop_idx;
  logic [WCHAR-1:0] shift;

  logic            strobe;
  logic            accept;
  logic            frame_ends;
  logic            tx_free;
  logic            consume;
  logic [WDIV-1:0] bit_reload;
  logic            next_active;
  logic            busy_next;

  // Payload bits above the character/divisor fields carry no meaning here.
  if (HW < WD - 1) begin : g_unused_payload
    logic unused_payload;
    assign unused_payload = ^push_d[WD-2:HW];
  end

  assign strobe     = push_d[WD];
  assign accept     = strobe && !hold_valid;
  assign push_retry = hold_valid;

  // A divisor of zero behaves as one clock per bit, so the reload saturates.
  assign bit_reload = (divisor == '0) ? '0 : (divisor - WDIV'(1));

  // The transmitter can take the held word while idle, or in the very last
  // cycle of the final stop bit so back-to-back frames have no idle gap.
  assign frame_ends = (state == STOP) && (cnt == '0) && (stop_idx == LAST_STOP);
  assign tx_free    = (state == IDLE) || frame_ends;
  assign consume    = hold_valid && tx_free;

  // Next-cycle busy, so busy_out can be a plain register.
  always_comb begin
    next_active = 1'b0;
    busy_next   = 1'b0;
    if (consume) begin
      next_active = !hold_cmd;
    end else begin
      next_active = (state != IDLE) && !frame_ends;
    end
    busy_next = accept || (hold_valid && !consume) || next_active;
  end

  // Holding register, divisor and the frame state machine with registered txd_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_cmd   <= 1'b0;
      hold_val   <= '0;
      divisor    <= WDIV'(DIV);
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      txd_out    <= 1'b1;
      busy_out   <= 1'b0;
    end else begin
      busy_out <= busy_next;

      // Accept and consume are mutually exclusive by construction.
      if (accept) begin
        hold_valid <= 1'b1;
        hold_cmd   <= push_d[WD-1];
        hold_val   <= push_d[HW-1:0];
      end else if (consume) begin
        hold_valid <= 1'b0;
      end

      if (consume) begin
        if (hold_cmd) begin
          // Divisor command: a single idle cycle, line stays high.
          divisor <= hold_val[WDIV-1:0];
          state   <= IDLE;
          cnt     <= '0;
          txd_out <= 1'b1;
        end else begin
          shift   <= hold_val[WCHAR-1:0];
          state   <= START;
          cnt     <= bit_reload;
          txd_out <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            txd_out <= 1'b1;
          end

          START: begin
            if (cnt == '0) begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= bit_reload;
              txd_out <= shift[0];
            end else begin
              cnt <= cnt - WDIV'(1);
            end
          end

          DATA: begin
            if (cnt == '0) begin
              cnt <= bit_reload;
              if (bit_idx == LAST_BIT) begin
                state    <= STOP;
                stop_idx <= 1'b0;
                txd_out  <= 1'b1;
              end else begin
                bit_idx <= bit_idx + BIW'(1);
                shift   <= shift >> 1;
                txd_out <= shift[1];
              end
            end else begin
              cnt <= cnt - WDIV'(1);
            end
          end

          STOP: begin
            if (cnt == '0) begin
              if (stop_idx == LAST_STOP) begin
                state   <= IDLE;
                txd_out <= 1'b1;
              end else begin
                stop_idx <= 1'b1;
                cnt      <= bit_reload;
              end
            end else begin
              cnt <= cnt - WDIV'(1);
            end
          end

          default: begin
            state   <= IDLE;
            txd_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_relm_uart_tx_io.sv
// Bench for relm_uart_tx_io: a serial-line monitor checks every frame against
// an expected queue of {bit_time, char}; table rows, directed sequences and
// random traffic feed that queue.
module tb_relm_uart_tx_io;

  localparam int WD    = 32;
  localparam int WCHAR = 8;
  localparam int WDIV  = 16;
  localparam int DIV   = 4;
  localparam int NSTOP = 1;
  localparam int FRAME_BITS = 1 + WCHAR + NSTOP;

  logic        clk;
  logic        rst_n;
  logic [WD:0] push_d;
  logic        push_retry;
  logic        txd_out;
  logic        busy_out;

  relm_uart_tx_io #(
    .WD(WD), .WCHAR(WCHAR), .WDIV(WDIV), .DIV(DIV), .NSTOP(NSTOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_d    (push_d),
    .push_retry(push_retry),
    .txd_out   (txd_out),
    .busy_out  (busy_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / line monitor ----------------
  logic [23:0] exp_q[$];   // {bit_time[15:0], char[7:0]}
  int          gap_q[$];   // idle cycles before each observed frame
  int          rd_idx   = 0;
  bit          in_frame = 0;
  bit          lost     = 0;
  bit          frame_ok;
  int          mj, m_bt, bad_j;
  int          last_end = -1000;
  logic [7:0]  m_ch;

  always @(negedge clk) begin
    logic [23:0] e;
    logic        exp_bit;
    int          k;
    if (!rst_n) begin
      in_frame = 0;
      lost     = 0;
      rd_idx   = exp_q.size();   // partial frame and held word are discarded
    end else begin
      if (lost && txd_out === 1'b1) lost = 0;
      if (!in_frame && !lost && txd_out !== 1'b1) begin
        if (rd_idx >= exp_q.size()) begin
          check("unexpected start bit", {63'd0, txd_out}, 64'd1);
          lost = 1;
        end else begin
          e        = exp_q[rd_idx];
          rd_idx   = rd_idx + 1;
          m_ch     = e[7:0];
          m_bt     = int'(e[23:8]);
          mj       = 0;
          frame_ok = 1;
          bad_j    = -1;
          gap_q.push_back(cyc - last_end - 1);
          in_frame = 1;
        end
      end
      if (in_frame) begin
        k = mj / m_bt;
        if (k == 0)          exp_bit = 1'b0;
        else if (k <= WCHAR) exp_bit = m_ch[k-1];
        else                 exp_bit = 1'b1;
        if (txd_out !== exp_bit && frame_ok) begin
          frame_ok = 0;
          bad_j    = mj;
        end
        mj++;
        if (mj == FRAME_BITS * m_bt) begin
          in_frame = 0;
          last_end = cyc;
          check($sformatf("frame ch=%02h bt=%0d first_bad_cycle=%0d", m_ch, m_bt, bad_j),
                {63'd0, frame_ok}, 64'd1);
        end
      end
    end
  end

  function automatic int gap_at(input int i);
    if (i < gap_q.size()) return gap_q[i];
    return -99;
  endfunction

  // ---------------- driver tasks ----------------
  int model_div = DIV;

  // Holds the word on the channel until an edge with retry low takes it.
  task automatic push_raw(input logic [WD-1:0] w, output int acc_cyc);
    int n;
    bit done;
    n = 0;
    done = 0;
    acc_cyc = -1;
    push_d = {1'b1, w};
    while (!done) begin
      @(negedge clk);
      if (push_retry === 1'b0) begin
        acc_cyc = cyc;
        done = 1;
      end else if (n >= 5000) begin
        check("push accept timeout", {63'd0, push_retry}, 64'd0);
        done = 1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    push_d = '0;
  endtask

  task automatic push_char(input logic [7:0] ch, input int bt, output int acc_cyc);
    exp_q.push_back({16'(bt), ch});
    push_raw({1'b0, 23'd0, ch}, acc_cyc);
  endtask

  task automatic push_cmd(input logic [30:0] v);
    int a;
    push_raw({1'b1, v}, a);
    model_div = (v[15:0] == 16'd0) ? 1 : int'(v[15:0]);
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (busy_out === 1'b0 && !in_frame) done = 1;
      else if (n > 20000) begin
        check("idle timeout", {63'd0, busy_out}, 64'd0);
        done = 1;
      end
      n++;
    end
    check("expected queue drained", 64'(exp_q.size() - rd_idx), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_cmd;
    logic [30:0] val;
    int          bt;    // expected clocks per bit for a character row
    int          gap;   // expected idle cycles before the frame, -1 = any
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  // ---------------- main sequence ----------------
  initial begin
    int t0, t1, t2, tl, hi, gb, idx, a, n;
    logic [43:0] act_txd, exp_txd, act_busy, exp_busy;
    logic [7:0]  ch;
    bit          done;

    tbl[0]  = '{1'b0, 31'h5A,      4, -1};
    tbl[1]  = '{1'b1, 31'd8,       0, -1};
    tbl[2]  = '{1'b0, 31'hC3,      8,  2};
    tbl[3]  = '{1'b0, 31'h3C,      8,  0};
    tbl[4]  = '{1'b1, 31'd2,       0, -1};
    tbl[5]  = '{1'b0, 31'h01,      2,  2};
    tbl[6]  = '{1'b1, 31'd0,       0, -1};
    tbl[7]  = '{1'b0, 31'hA5,      1,  2};
    tbl[8]  = '{1'b0, 31'h5A,      1,  0};
    tbl[9]  = '{1'b1, 31'h10003,   0, -1};
    tbl[10] = '{1'b0, 31'h96,      3,  2};
    tbl[11] = '{1'b1, 31'd4,       0, -1};
    tbl[12] = '{1'b0, 31'hE7,      4,  2};

    rst_n  = 1'b0;
    push_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset txd", {63'd0, txd_out}, 64'd1);
    check("reset retry", {63'd0, push_retry}, 64'd0);
    check("reset busy", {63'd0, busy_out}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset txd", {63'd0, txd_out}, 64'd1);
    check("post-reset retry", {63'd0, push_retry}, 64'd0);
    check("post-reset busy", {63'd0, busy_out}, 64'd0);

    // Single character 0x55 at DIV=4, cycle-exact waveform.
    @(posedge clk);
    #1;
    ch = 8'h55;
    exp_q.push_back({16'd4, ch});
    push_d = {1'b1, 1'b0, 31'h55};
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (c == 0) check("retry in accept cycle", {63'd0, push_retry}, 64'd0);
      act_txd[c]  = txd_out;
      act_busy[c] = busy_out;
      if (c >= 2 && c <= 5)       exp_txd[c] = 1'b0;
      else if (c >= 6 && c <= 37) exp_txd[c] = ch[(c-6)/4];
      else                        exp_txd[c] = 1'b1;
      exp_busy[c] = (c >= 1 && c <= 41);
      @(posedge clk);
      #1;
      if (c == 0) push_d = '0;
    end
    check("single char txd waveform", 64'(act_txd), 64'(exp_txd));
    check("single char busy waveform", 64'(act_busy), 64'(exp_busy));
    wait_idle();

    // Back-pressure: second word waits one cycle, third is refused while held.
    gb = gap_q.size();
    push_char(8'hA3, 4, t0);
    push_char(8'h0F, 4, t1);
    check("second word accept cycle", 64'(t1 - t0), 64'd2);
    push_d = {1'b1, 1'b0, 31'h3C};
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (push_retry === 1'b1) hi++;
      @(posedge clk);
      #1;
    end
    push_d = '0;
    check("retry held while word waits", 64'(hi), 64'd6);
    n = 0;
    done = 0;
    tl = -1;
    while (!done) begin
      @(negedge clk);
      if (push_retry === 1'b0) begin
        tl = cyc;
        done = 1;
        check("start bit right after stop", {63'd0, txd_out}, 64'd0);
      end else if (n > 200) begin
        check("retry release timeout", {63'd0, push_retry}, 64'd0);
        done = 1;
      end
      n++;
    end
    check("retry release cycle", 64'(tl - t0), 64'd42);
    @(posedge clk);
    #1;
    push_char(8'h3C, 4, t2);
    wait_idle();
    check("backpressure frame count", 64'(gap_q.size() - gb), 64'd3);
    check("gap before 0F", 64'(gap_at(gb + 1)), 64'd0);
    check("gap before resent 3C", 64'(gap_at(gb + 2)), 64'd0);

    // Table: characters interleaved with divisor commands, pushed back to back.
    gb = gap_q.size();
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].is_cmd) push_cmd(tbl[i].val);
      else               push_char(tbl[i].val[7:0], tbl[i].bt, a);
    end
    wait_idle();
    idx = 0;
    for (int i = 0; i < NV; i++) begin
      if (!tbl[i].is_cmd) begin
        if (tbl[i].gap >= 0)
          check($sformatf("table row %0d gap", i), 64'(gap_at(gb + idx)), 64'(tbl[i].gap));
        idx++;
      end
    end
    check("table frame count", 64'(gap_q.size() - gb), 64'(idx));

    // Random traffic: characters, commands and strobe-less noise.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) begin
        push_d = {1'b0, WD'($urandom())};
        @(posedge clk);
        #1;
      end
      push_d = '0;
      if ($urandom_range(0, 3) == 0)
        push_cmd({15'($urandom()), 16'($urandom_range(0, 5))});
      else
        push_char(8'($urandom_range(0, 255)), model_div, a);
    end
    wait_idle();

    // Reset mid-frame with a word held: line goes high at once, all discarded.
    push_cmd(31'd2);
    push_char(8'h00, 2, a);
    push_char(8'h7E, 2, a);
    #2;
    check("txd low before reset", {63'd0, txd_out}, 64'd0);
    check("busy before reset", {63'd0, busy_out}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset txd", {63'd0, txd_out}, 64'd1);
    check("async reset retry", {63'd0, push_retry}, 64'd0);
    check("async reset busy", {63'd0, busy_out}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_div = DIV;
    repeat (30) @(negedge clk);
    check("line idle after reset", {63'd0, txd_out}, 64'd1);
    check("held word discarded", {63'd0, busy_out}, 64'd0);
    @(posedge clk);
    #1;
    push_char(8'h69, model_div, a);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
